dram_axi_bridge: RTL
====================

// Module: dram_axi_bridge
// PURPOSE
//  CPU-side bridge that turns the single-word DRAM request port (oe/addr/wdata/we -> rdata/valid/busy) into
//  single-beat AXI4 transactions on the 128-bit S_AXI port of the MIG block. It sits directly upstream of the
//  MIG, in the same clock domain, with one outstanding transaction at a time.
// PARAMETERS
//  ADDR_W     32             CPU byte-address width
//  AXI_DW     128            AXI data width (fixed 4 x 32-bit lanes)
//  ADDR_MASK  32'h07FF_FFFF  AND-mask applied to dram_addr before issue (128 MiB window)
// PORTS
//  clk          in   1    clock; the AXI interface runs on this clock (drives MIG clk_axi)
//  rst          in   1    synchronous, active-high reset
//  calib_done   in   1    MIG calibration complete; no request is accepted while low
//  dram_oe      in   1    request strobe; sampled only when dram_busy==0
//  dram_addr    in   32   byte address; [1:0] ignored
//  dram_wdata   in   32   write word
//  dram_we      in   4    byte enables; nonzero=write, zero=read
//  dram_rdata   out  32   read word; valid while dram_valid==1
//  dram_valid   out  1    1-cycle read-completion pulse
//  dram_busy    out  1    combinational: state!=IDLE || !calib_done
//  dram_err     out  1    sticky; set on any bresp/rresp != OKAY, cleared only by rst
//  m_aw*/m_w*/m_b*/m_ar*/m_r*  AXI4 master; full signal set of the MIG S_AXI port, same widths
// BEHAVIOUR
//  Reset: state=IDLE; all *valid=0; bready=rready=0; dram_valid=0; dram_rdata=0; dram_err=0; latched addr/data=0.
//  Constants: len=0, size=3'b100, burst=2'b01, cache=4'b0011, id/lock/prot/qos/region=0, wlast=1.
//  Issue: awaddr/araddr={A[31:4],4'b0} with A=dram_addr&ADDR_MASK; lane L=A[3:2];
//    wdata={4{dram_wdata}}; wstrb=16'(dram_we)<<(4*L). All are registered at acceptance and held stable.
//  FSM: IDLE -> WR_REQ (oe&&we!=0) | RD_REQ (oe&&we==0); accepting a request takes 1 cycle.
//   WR_REQ: awvalid and wvalid both asserted; each drops independently on its own ready handshake;
//     when both are done -> WR_RESP. The slave may return awready/wready in the same or different cycles.
//   WR_RESP: bready=1; on bvalid -> IDLE; err|=(bresp!=0). There is no CPU completion pulse for writes.
//   RD_REQ: arvalid=1 until arready -> RD_DATA.
//   RD_DATA: rready=1; on rvalid: dram_rdata<=rdata[32*L+:32], dram_valid<=1 (next cycle), err|=(rresp!=0) -> IDLE.
//  Latency: a read completes rvalid-cycle + 1; back-to-back requests are allowed on the cycle busy falls.
//  dram_oe is ignored while busy. A request that arrives when calib_done==0 is dropped (busy is high).
//  Mid-operation rst aborts the transaction; rst must be applied to the MIG simultaneously.
//  A valid signal is never withdrawn before its handshake. Payload signals do not change while valid is high.
// CONFIGURATION
//  DRAM_LINEBUF_EN defined: adds a 1-entry 128-bit line buffer with tag {A[31:4]} and valid bit.
//    The tag is filled on each AXI read. A read hit returns dram_valid on the next cycle with no AXI traffic,
//    and busy stays 0. A write to the tagged line merges its bytes into the buffer (write-through; AXI still issued).
//    rst and any bresp/rresp error invalidate the buffer.
//  Undefined: every read goes to AXI; no extra storage.
// STRUCTURE
//  Shared package dram_axi_pkg: FSM state encoding (IDLE/WR_REQ/WR_RESP/RD_REQ/RD_DATA), AXI constants
//   (SIZE_16B, BURST_INCR, RESP_OKAY, CACHE_BUF), and a lane-select function.
//  Optional sub-module dram_linebuf (tag/data/merge) is instantiated only under DRAM_LINEBUF_EN.
// TESTING
//  1 Write: addr=0x0000_0014, wdata=0xDEADBEEF, we=4'hF -> awaddr=0x10, wstrb=16'h00F0,
//    wdata lane1=0xDEADBEEF, one B handshake, busy low afterwards.
//  2 Read-back: read 0x14 -> araddr=0x10; rdata lane1 -> dram_rdata=0xDEADBEEF, dram_valid exactly 1 cycle.
//  3 Split handshake: slave gives awready 3 cycles before wready -> awvalid drops alone,
//    wvalid holds until wready, exactly one write occurs.
//  4 Calibration/busy: calib_done=0 with oe pulsed -> no AXI activity and busy=1;
//    an oe asserted during RD_DATA is ignored.
//  5 Error/reset: rresp=2'b10 -> dram_err=1 and sticky; rst asserted in WR_REQ
//    -> all valids 0 next cycle, state IDLE, err=0.
//  6 DRAM_LINEBUF_EN: two reads of 0x20 -> second read makes no AR and returns valid 1 cycle later;
//    write we=4'h1 to 0x20 then read -> merged byte is returned.

Source files
------------

// File: rtl/dram_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dram_axi_pkg
// Purpose  : Shared definitions for the DRAM-to-AXI bridge: FSM state
//            encoding, fixed AXI attribute constants and a 32-bit lane
//            selector for 128-bit AXI data words.
// Optional : DRAM_LINEBUF_EN (used by the bridge, not by this package)
// Revision : 1.0 - initial release
// ============================================================================
package dram_axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  localparam logic [2:0] SIZE_16B   = 3'b100;   // 16 bytes per beat
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [3:0] CACHE_BUF  = 4'b0011;  // normal, non-cacheable, bufferable

  // Pick 32-bit lane 'lane' out of a 128-bit AXI data word.
  function automatic logic [31:0] lane_sel(input logic [127:0] line, input logic [1:0] lane);
    return line[32*lane +: 32];
  endfunction

endpackage
`default_nettype wire

// File: rtl/dram_axi_bridge_if.sv
`default_nettype none
// ============================================================================
// Interface: dram_axi_bridge_if
// Purpose  : AXI4 bus matching the MIG S_AXI port (single clock domain).
// Modports : master - driven by the bridge; slave - driven by the MIG side.
// Params   : ADDR_W address width, DATA_W data width, ID_W id width.
// Revision : 1.0 - initial release
// ============================================================================
interface dram_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int ID_W   = 4
);
  // write address
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic [3:0]          awregion;
  logic                awvalid;
  logic                awready;
  // write data
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  // write response
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  // read address
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic [3:0]          arregion;
  logic                arvalid;
  logic                arready;
  // read data
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface
`default_nettype wire

// File: rtl/dram_axi_bridge_linebuf.sv
`default_nettype none
// ============================================================================
// Module   : dram_linebuf
// Purpose  : One-entry 128-bit read line buffer with tag and valid bit.
//            Filled from AXI read data, byte-merged by writes that hit the
//            tagged line (write-through), invalidated on reset or error.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            lookup_tag / hit    - tag compare for the incoming request
//            line                - buffered line data
//            fill_*              - load a complete line
//            merge_*             - byte-merge write data into a hit line
//            inval               - drop the entry
// Optional : compiled only when DRAM_LINEBUF_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
`ifdef DRAM_LINEBUF_EN
module dram_linebuf #(
  parameter int TAG_W  = 28,
  parameter int LINE_W = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TAG_W-1:0]    lookup_tag,
  output logic                hit,
  output logic [LINE_W-1:0]   line,
  input  logic                fill_en,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [LINE_W-1:0]   fill_data,
  input  logic                merge_en,
  input  logic [LINE_W-1:0]   merge_data,
  input  logic [LINE_W/8-1:0] merge_strb,
  input  logic                inval
);
  logic              r_valid;
  logic [TAG_W-1:0]  r_tag;
  logic [LINE_W-1:0] r_data;

  assign hit  = r_valid && (r_tag == lookup_tag);
  assign line = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (inval) begin
      r_valid <= 1'b0;
    end else if (fill_en) begin
      r_valid <= 1'b1;
      r_tag   <= fill_tag;
      r_data  <= fill_data;
    end else if (merge_en && hit) begin
      for (int i = 0; i < LINE_W/8; i++) begin
        if (merge_strb[i]) r_data[8*i +: 8] <= merge_data[8*i +: 8];
      end
    end
  end
endmodule
`endif
`default_nettype wire

// File: rtl/dram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dram_axi_bridge
// Purpose  : Converts single-word CPU DRAM requests into single-beat AXI4
//            transactions on the 128-bit MIG S_AXI port, one at a time.
// Ports    : clk, rst            - clock (also MIG clk_axi), sync active-high reset
//            calib_done          - MIG calibration complete
//            dram_oe/addr/wdata/we - CPU request (we!=0 write, we==0 read)
//            dram_rdata/valid    - read data and 1-cycle completion pulse
//            dram_busy           - request port not accepting
//            dram_err            - sticky AXI error flag
//            m                   - AXI4 master (dram_axi_bridge_if.master)
// Optional : DRAM_LINEBUF_EN adds a 1-entry read line buffer (dram_linebuf)
// Revision : 1.0 - initial release
// ============================================================================
module dram_axi_bridge
  import dram_axi_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                AXI_DW    = 128,
  parameter logic [ADDR_W-1:0] ADDR_MASK = 32'h07FF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              calib_done,
  input  logic              dram_oe,
  input  logic [ADDR_W-1:0] dram_addr,
  input  logic [31:0]       dram_wdata,
  input  logic [3:0]        dram_we,
  output logic [31:0]       dram_rdata,
  output logic              dram_valid,
  output logic              dram_busy,
  output logic              dram_err,
  dram_axi_bridge_if.master m
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [AXI_DW-1:0]   r_wdata;
  logic [AXI_DW/8-1:0] r_wstrb;
  logic [1:0]          r_lane;
  logic                r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [31:0]         r_rdata;
  logic                r_valid, r_err;

  logic [ADDR_W-1:0]   w_addr_m;
  logic [1:0]          w_lane;
  logic [AXI_DW-1:0]   w_wdata_rep;
  logic [AXI_DW/8-1:0] w_strb;
  logic                w_accept, w_is_wr, w_hit;
  logic                w_lb_hit;
  logic [AXI_DW-1:0]   w_lb_line;
  logic                w_aw_done, w_w_done;
  logic                w_unused;

  assign w_addr_m    = dram_addr & ADDR_MASK;
  assign w_lane      = w_addr_m[3:2];
  assign w_wdata_rep = {4{dram_wdata}};
  assign w_strb      = {12'd0, dram_we} << {w_lane, 2'b00};
  assign w_is_wr     = |dram_we;
  assign w_accept    = (r_state == IDLE) && calib_done && dram_oe;
  assign w_hit       = w_lb_hit && !w_is_wr;

  // A channel counts as done if it already handshook or handshakes this cycle.
  assign w_aw_done = !r_awvalid || m.awready;
  assign w_w_done  = !r_wvalid  || m.wready;

  // IDs, rlast and the sub-word address bits carry no information here.
  assign w_unused = ^{m.bid, m.rid, m.rlast, dram_addr[1:0]};

`ifdef DRAM_LINEBUF_EN
  logic w_lb_inval;
  assign w_lb_inval = ((r_state == WR_RESP) && m.bvalid && (m.bresp != RESP_OKAY)) ||
                      ((r_state == RD_DATA) && m.rvalid && (m.rresp != RESP_OKAY));

  dram_linebuf #(
    .TAG_W  (ADDR_W-4),
    .LINE_W (AXI_DW)
  ) u_linebuf (
    .clk        (clk),
    .rst        (rst),
    .lookup_tag (w_addr_m[ADDR_W-1:4]),
    .hit        (w_lb_hit),
    .line       (w_lb_line),
    .fill_en    ((r_state == RD_DATA) && m.rvalid && (m.rresp == RESP_OKAY)),
    .fill_tag   (r_addr[ADDR_W-1:4]),
    .fill_data  (m.rdata),
    .merge_en   (w_accept && w_is_wr),
    .merge_data (w_wdata_rep),
    .merge_strb (w_strb),
    .inval      (w_lb_inval)
  );
`else
  assign w_lb_hit  = 1'b0;
  assign w_lb_line = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_lane    <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rdata   <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr  <= {w_addr_m[ADDR_W-1:4], 4'b0000};
            r_lane  <= w_lane;
            r_wdata <= w_wdata_rep;
            r_wstrb <= w_strb;
            if (w_is_wr) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR_REQ;
            end else if (w_hit) begin
              // Served from the line buffer: stay idle, no AXI traffic.
              r_rdata <= lane_sel(w_lb_line, w_lane);
              r_valid <= 1'b1;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (r_awvalid && m.awready) r_awvalid <= 1'b0;
          if (r_wvalid && m.wready)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m.bvalid) begin
            r_bready <= 1'b0;
            r_err    <= r_err | (m.bresp != RESP_OKAY);
            r_state  <= IDLE;
          end
        end
        RD_REQ: begin
          if (m.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m.rvalid) begin
            r_rready <= 1'b0;
            r_rdata  <= lane_sel(m.rdata, r_lane);
            r_valid  <= 1'b1;
            r_err    <= r_err | (m.rresp != RESP_OKAY);
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dram_rdata = r_rdata;
  assign dram_valid = r_valid;
  assign dram_err   = r_err;
  assign dram_busy  = (r_state != IDLE) || !calib_done;

  assign m.awid     = '0;
  assign m.awaddr   = r_addr;
  assign m.awlen    = 8'd0;
  assign m.awsize   = SIZE_16B;
  assign m.awburst  = BURST_INCR;
  assign m.awlock   = 1'b0;
  assign m.awcache  = CACHE_BUF;
  assign m.awprot   = 3'b000;
  assign m.awqos    = 4'd0;
  assign m.awregion = 4'd0;
  assign m.awvalid  = r_awvalid;
  assign m.wdata    = r_wdata;
  assign m.wstrb    = r_wstrb;
  assign m.wlast    = 1'b1;
  assign m.wvalid   = r_wvalid;
  assign m.bready   = r_bready;
  assign m.arid     = '0;
  assign m.araddr   = r_addr;
  assign m.arlen    = 8'd0;
  assign m.arsize   = SIZE_16B;
  assign m.arburst  = BURST_INCR;
  assign m.arlock   = 1'b0;
  assign m.arcache  = CACHE_BUF;
  assign m.arprot   = 3'b000;
  assign m.arqos    = 4'd0;
  assign m.arregion = 4'd0;
  assign m.arvalid  = r_arvalid;
  assign m.rready   = r_rready;

endmodule
`default_nettype wire
